// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the fetch/data cache-port arbiter.
package mem_arb_pkg;

    localparam logic CACHE_READ  = 1'b0;
    localparam logic CACHE_WRITE = 1'b1;
    localparam logic PORT_FETCH  = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and cache-side signals around the shared cache port.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Every channel is valid/ready: a transfer happens in a cycle where both are high;
    // once valid is raised the sender keeps valid and its payload stable until that cycle.
    logic              r0_valid;
    logic              r0_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic              r1_valid;
    logic              r1_ready;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_op;
    logic [DATA_W-1:0] r1_wdata;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_op;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [DATA_W-1:0] mem_rsp_data;

    modport slave (
        input  r0_valid, r0_addr, r1_valid, r1_addr, r1_op, r1_wdata,
        input  rsp0_ready, rsp1_ready, mem_ready, mem_rsp_valid, mem_rsp_data,
        output r0_ready, r1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output mem_valid, mem_addr, mem_op, mem_wdata, mem_rsp_ready
    );

    modport master (
        output r0_valid, r0_addr, r1_valid, r1_addr, r1_op, r1_wdata,
        output rsp0_ready, rsp1_ready, mem_ready, mem_rsp_valid, mem_rsp_data,
        input  r0_ready, r1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  mem_valid, mem_addr, mem_op, mem_wdata, mem_rsp_ready
    );

endinterface

// File: rtl/tag_fifo.sv
// In-order FIFO of 1-bit requester ids, one entry per outstanding cache read.
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             head_id_o,
    output logic [CNT_W-1:0] count_o
);
    logic [DEPTH-1:0] ids_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_id_o = ids_q[rd_ptr_q];
    assign count_o   = count_q;

    // Full/empty come from the registered count, so a same-cycle pop never makes room for a push.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                ids_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache port between fetch (port 0) and data (port 1),
// steering each read response back to its requester through an in-order tag FIFO.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_orphan_rsp,
    output arb_state_e        dbg_state_o
);
    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d, sel;
    logic             last_grant_q, last_grant_d;
    logic             err_q, err_d;
    logic             elig0, elig1, mem_valid, accept, is_read;
    logic             fifo_full, fifo_empty, head_id, push, pop, rsp_ready;
    logic [CNT_W-1:0] fifo_count;

    // Writes never occupy a tag slot, so a full FIFO only blocks reads.
    assign elig0 = bus.r0_valid & ~fifo_full;
    assign elig1 = bus.r1_valid & ((bus.r1_op == CACHE_WRITE) | ~fifo_full);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        sel          = sel_q;
        mem_valid    = 1'b0;
        case (state_q)
            ARB_UNLOCKED: begin
                mem_valid = elig0 | elig1;
                if (elig0 && elig1) begin
                    sel = ~last_grant_q;
                end else if (elig0) begin
                    sel = PORT_FETCH;
                end else begin
                    sel = PORT_DATA;
                end
            end
            ARB_LOCKED: begin
                mem_valid = 1'b1;
                sel       = sel_q;
            end
            default: begin
                mem_valid = 1'b0;
            end
        endcase
        if (mem_valid && !bus.mem_ready) begin
            state_d = ARB_LOCKED;
            sel_d   = sel;
        end
        if (mem_valid && bus.mem_ready) begin
            state_d      = ARB_UNLOCKED;
            last_grant_d = sel;
        end
    end

    always_comb begin
        if (sel == PORT_FETCH) begin
            bus.mem_addr  = bus.r0_addr;
            bus.mem_op    = CACHE_READ;
            bus.mem_wdata = '0;
        end else begin
            bus.mem_addr  = bus.r1_addr;
            bus.mem_op    = bus.r1_op;
            bus.mem_wdata = bus.r1_wdata;
        end
    end

    assign bus.mem_valid = mem_valid;
    assign accept        = mem_valid & bus.mem_ready;
    assign bus.r0_ready  = accept & (sel == PORT_FETCH);
    assign bus.r1_ready  = accept & (sel == PORT_DATA);
    assign is_read       = (sel == PORT_FETCH) | (bus.r1_op == CACHE_READ);
    assign push          = accept & is_read;

    // With no tag outstanding the response is swallowed and flagged rather than stalling the cache.
    assign rsp_ready         = fifo_empty ? 1'b1 :
                               ((head_id == PORT_FETCH) ? bus.rsp0_ready : bus.rsp1_ready);
    assign bus.mem_rsp_ready = rsp_ready;
    assign bus.rsp0_valid    = bus.mem_rsp_valid & ~fifo_empty & (head_id == PORT_FETCH);
    assign bus.rsp1_valid    = bus.mem_rsp_valid & ~fifo_empty & (head_id == PORT_DATA);
    assign bus.rsp0_data     = bus.mem_rsp_data;
    assign bus.rsp1_data     = bus.mem_rsp_data;
    assign pop               = bus.mem_rsp_valid & rsp_ready & ~fifo_empty;
    assign err_d             = err_q | (bus.mem_rsp_valid & fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_UNLOCKED;
            sel_q        <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .push_id_i (sel),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_id_o (head_id),
        .count_o   (fifo_count)
    );

    assign outstanding    = fifo_count;
    assign err_orphan_rsp = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] outstanding;
    logic             err_orphan_rsp;
    arb_state_e       dbg_state;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .outstanding    (outstanding),
        .err_orphan_rsp (err_orphan_rsp),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    int                tags[$];          // owner of each outstanding read, oldest first
    logic [DATA_W-1:0] exp0_q[$];        // data port 0 expects, in order
    logic [DATA_W-1:0] exp1_q[$];
    logic [DATA_W-1:0] cache_q[$];       // responses the cache still owes
    int                last_winner;
    int                held;             // port whose grant is pending acceptance, -1 if none
    bit                m_err;

    bit                e_valid, e_acc, e_read, e_rsp_rdy, e_rsp0_v, e_rsp1_v, e_pop;
    int                e_win;
    logic [DATA_W-1:0] e_req_data, e_cache_data;
    bit                acc0_last, acc1_last, rsp_taken_last;

    function automatic logic [DATA_W-1:0] cache_data(input logic [ADDR_W-1:0] a);
        return a ^ 32'hDEADBEAF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluate the model for the currently driven inputs and compare every DUT output.
    task automatic settle();
        bit full, el0, el1;
        #1;
        full = (tags.size() == DEPTH);
        el0  = bus.r0_valid && !full;
        el1  = bus.r1_valid && (bus.r1_op || !full);
        if (held >= 0) begin
            e_valid = 1; e_win = held;
        end else if (el0 && el1) begin
            e_valid = 1; e_win = 1 - last_winner;
        end else if (el0) begin
            e_valid = 1; e_win = 0;
        end else if (el1) begin
            e_valid = 1; e_win = 1;
        end else begin
            e_valid = 0; e_win = 0;
        end
        e_acc        = e_valid && bus.mem_ready;
        e_read       = (e_win == 0) || (bus.r1_op == CACHE_READ);
        e_req_data   = cache_data((e_win == 0) ? bus.r0_addr : bus.r1_addr);
        e_cache_data = cache_data(bus.mem_addr);
        chk("dbg_locked", dbg_state == ARB_LOCKED, held >= 0);
        chk("mem_valid", bus.mem_valid, e_valid);
        chk("r0_ready", bus.r0_ready, e_acc && e_win == 0);
        chk("r1_ready", bus.r1_ready, e_acc && e_win == 1);
        if (e_valid) begin
            chk("mem_addr", bus.mem_addr, (e_win == 0) ? bus.r0_addr : bus.r1_addr);
            chk("mem_op", bus.mem_op, (e_win == 0) ? 1'b0 : bus.r1_op);
            chk("mem_wdata", bus.mem_wdata, (e_win == 0) ? 32'h0 : bus.r1_wdata);
        end
        if (tags.size() == 0) begin
            e_rsp_rdy = 1; e_rsp0_v = 0; e_rsp1_v = 0;
        end else begin
            e_rsp_rdy = (tags[0] == 0) ? bus.rsp0_ready : bus.rsp1_ready;
            e_rsp0_v  = bus.mem_rsp_valid && tags[0] == 0;
            e_rsp1_v  = bus.mem_rsp_valid && tags[0] == 1;
        end
        e_pop = bus.mem_rsp_valid && e_rsp_rdy && tags.size() > 0;
        chk("mem_rsp_ready", bus.mem_rsp_ready, e_rsp_rdy);
        chk("rsp0_valid", bus.rsp0_valid, e_rsp0_v);
        chk("rsp1_valid", bus.rsp1_valid, e_rsp1_v);
        if (e_rsp0_v && bus.rsp0_ready && exp0_q.size() > 0)
            chk("rsp0_data", bus.rsp0_data, exp0_q[0]);
        if (e_rsp1_v && bus.rsp1_ready && exp1_q.size() > 0)
            chk("rsp1_data", bus.rsp1_data, exp1_q[0]);
        chk("outstanding", outstanding, tags.size());
        chk("err_orphan_rsp", err_orphan_rsp, m_err);
    endtask

    // Advance one clock and apply the same cycle's effects to the model.
    task automatic tick();
        @(posedge clk);
        if (e_pop) begin
            if (tags[0] == 0) void'(exp0_q.pop_front());
            else              void'(exp1_q.pop_front());
            void'(tags.pop_front());
            if (cache_q.size() > 0) void'(cache_q.pop_front());
        end else if (bus.mem_rsp_valid && tags.size() == 0) begin
            m_err = 1;
        end
        if (e_acc) begin
            last_winner = e_win;
            held        = -1;
            if (e_read) begin
                tags.push_back(e_win);
                if (e_win == 0) exp0_q.push_back(e_req_data);
                else            exp1_q.push_back(e_req_data);
                cache_q.push_back(e_cache_data);
            end
        end else if (e_valid) begin
            held = e_win;
        end
        acc0_last      = e_acc && e_win == 0;
        acc1_last      = e_acc && e_win == 1;
        rsp_taken_last = e_pop;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.r0_valid      = 0; bus.r0_addr  = '0;
        bus.r1_valid      = 0; bus.r1_addr  = '0;
        bus.r1_op         = CACHE_READ; bus.r1_wdata = '0;
        bus.rsp0_ready    = 1; bus.rsp1_ready = 1;
        bus.mem_ready     = 1;
        bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    endtask

    task automatic present_rsp();
        if (cache_q.size() > 0) begin
            bus.mem_rsp_valid = 1;
            bus.mem_rsp_data  = cache_q[0];
        end else begin
            bus.mem_rsp_valid = 0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        tags.delete(); exp0_q.delete(); exp1_q.delete(); cache_q.delete();
        last_winner = 1; held = -1; m_err = 0;
        acc0_last = 0; acc1_last = 0; rsp_taken_last = 0;
        settle();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_orphan_rsp, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        tick();
    endtask

    logic [ADDR_W-1:0] rr_addr[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rr_addr = '{32'h1000, 32'h2010, 32'h1020, 32'h2030};
        do_reset();

        // Single fetch
        bus.r0_valid = 1; bus.r0_addr = 32'h40;
        settle(); chk("fetch_r0_ready", bus.r0_ready, 1); tick();
        bus.r0_valid = 0;
        settle(); chk("fetch_outstanding", outstanding, 1); tick();
        present_rsp();
        settle();
        chk("fetch_rsp0_valid", bus.rsp0_valid, 1);
        chk("fetch_rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
        chk("fetch_rsp1_valid", bus.rsp1_valid, 0);
        tick();
        bus.mem_rsp_valid = 0;
        settle(); chk("fetch_drained", outstanding, 0); tick();

        // Contention from a fresh reset: 0,1,0,1 then in-order routing
        do_reset();
        bus.r0_valid = 1; bus.r1_valid = 1; bus.r1_op = CACHE_READ;
        for (int i = 0; i < 4; i++) begin
            bus.r0_addr = 32'h1000 + 32'(i * 16);
            bus.r1_addr = 32'h2000 + 32'(i * 16);
            settle();
            chk("rr_r0_grant", bus.r0_ready, (i % 2) == 0);
            chk("rr_r1_grant", bus.r1_ready, (i % 2) == 1);
            tick();
        end
        bus.r0_valid = 0; bus.r1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            present_rsp();
            settle();
            chk("rr_rsp_port", bus.rsp1_valid, (i % 2) == 1);
            chk("rr_rsp_data", (i % 2) ? bus.rsp1_data : bus.rsp0_data, cache_data(rr_addr[i]));
            tick();
        end
        bus.mem_rsp_valid = 0;

        // Lock on a stalled write while fetch waits
        bus.r1_valid = 1; bus.r1_op = CACHE_WRITE; bus.r1_addr = 32'h100;
        bus.r1_wdata = 32'hCAFEF00D; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin bus.r0_valid = 1; bus.r0_addr = 32'h300; end
            settle();
            chk("lock_addr", bus.mem_addr, 32'h100);
            chk("lock_op", bus.mem_op, 1);
            chk("lock_r0_ready", bus.r0_ready, 0);
            tick();
        end
        bus.mem_ready = 1;
        settle(); chk("lock_r1_accept", bus.r1_ready, 1); tick();
        bus.r1_valid = 0;
        settle();
        chk("lock_r0_next", bus.r0_ready, 1);
        chk("lock_write_no_tag", outstanding, 0);
        tick();
        bus.r0_valid = 0;
        present_rsp(); step();
        bus.mem_rsp_valid = 0;

        // Full FIFO blocks reads but not writes
        bus.r0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.r0_addr = 32'h400 + 32'(i * 4);
            step();
        end
        bus.r0_addr = 32'h500;
        bus.r1_valid = 1; bus.r1_op = CACHE_WRITE; bus.r1_addr = 32'h600; bus.r1_wdata = 32'h1234;
        settle();
        chk("full_outstanding", outstanding, 4);
        chk("full_r0_blocked", bus.r0_ready, 0);
        chk("full_r1_write", bus.r1_ready, 1);
        tick();
        bus.r1_valid = 0;
        present_rsp();
        settle(); chk("full_pop_no_same_cycle_push", bus.r0_ready, 0); tick();
        bus.mem_rsp_valid = 0;
        settle();
        chk("full_r0_granted", bus.r0_ready, 1);
        chk("full_after_pop", outstanding, 3);
        tick();
        bus.r0_valid = 0;
        for (int i = 0; i < 4; i++) begin present_rsp(); step(); end
        bus.mem_rsp_valid = 0;

        // Response backpressure on port 1
        bus.r1_valid = 1; bus.r1_op = CACHE_READ; bus.r1_addr = 32'h700;
        step();
        bus.r1_valid = 0; bus.rsp1_ready = 0;
        present_rsp();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("bp_mem_rsp_ready", bus.mem_rsp_ready, 0);
            chk("bp_rsp1_valid", bus.rsp1_valid, 1);
            chk("bp_no_pop", outstanding, 1);
            tick();
        end
        bus.rsp1_ready = 1;
        settle(); chk("bp_release", bus.mem_rsp_ready, 1); tick();
        bus.mem_rsp_valid = 0;
        settle(); chk("bp_popped", outstanding, 0); tick();

        // Orphan response with empty FIFO
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = $urandom;
        settle();
        chk("orphan_ready", bus.mem_rsp_ready, 1);
        chk("orphan_rsp0", bus.rsp0_valid, 0);
        chk("orphan_rsp1", bus.rsp1_valid, 0);
        tick();
        bus.mem_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("orphan_sticky", err_orphan_rsp, 1); tick();
        end

        // Randomized traffic; requesters and cache hold payloads until accepted
        for (int c = 0; c < 400; c++) begin
            if (!bus.r0_valid || acc0_last) begin
                bus.r0_valid = ($urandom_range(0, 2) != 0);
                bus.r0_addr  = $urandom;
            end
            if (!bus.r1_valid || acc1_last) begin
                bus.r1_valid = ($urandom_range(0, 2) != 0);
                bus.r1_addr  = $urandom;
                bus.r1_op    = 1'($urandom_range(0, 1));
                bus.r1_wdata = $urandom;
            end
            bus.mem_ready  = ($urandom_range(0, 3) != 0);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            if (!bus.mem_rsp_valid || rsp_taken_last) begin
                if ($urandom_range(0, 1) == 1) present_rsp();
                else bus.mem_rsp_valid = 0;
            end
            step();
        end

        // Drain everything still in flight
        bus.mem_ready = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int c = 0; c < 64; c++) begin
            if (acc0_last) bus.r0_valid = 0;
            if (acc1_last) bus.r1_valid = 0;
            if (!bus.mem_rsp_valid || rsp_taken_last) present_rsp();
            step();
        end
        idle_inputs();
        settle(); chk("drain_outstanding", outstanding, 0); tick();

        // Reset with two reads outstanding, then a stale response
        bus.r0_valid = 1; bus.r0_addr = 32'h800; step();
        bus.r0_valid = 0;
        bus.r1_valid = 1; bus.r1_op = CACHE_READ; bus.r1_addr = 32'h900; step();
        bus.r1_valid = 0;
        settle(); chk("pre_reset_outstanding", outstanding, 2); tick();
        do_reset();
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = cache_data(32'h800);
        settle(); chk("stale_rsp_ready", bus.mem_rsp_ready, 1); tick();
        bus.mem_rsp_valid = 0;
        settle(); chk("stale_rsp_err", err_orphan_rsp, 1); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
